// File: rtl/dso_uart_pkg.sv
// Shared types and constants for the scope's host UART command link.
package dso_uart_pkg;

    localparam int CMD_BYTES    = 3;
    localparam int DEF_BAUD_DIV = 2604;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// UART transmitter: 8N1 framing, one bit every BAUD_DIV clocks, LSB first.
module uart_tx_core
    import dso_uart_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       tx_busy
);

    localparam int            BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;

    // The line is driven straight from the shift register LSB; all-ones means idle.
    assign TX = shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '1;
            tx_done  <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (trmt) begin
                        shift    <= {1'b1, tx_data, 1'b0};
                        baud_cnt <= BAUD_LAST;
                        bit_cnt  <= '0;
                        tx_busy  <= 1'b1;
                        tx_done  <= 1'b0;
                        state    <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else if (bit_cnt == 4'd9) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= TX_IDLE;
                    end else begin
                        shift    <= {1'b1, shift[9:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        baud_cnt <= BAUD_LAST;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_uart_link.sv
// Host serial link: assembles three received UART bytes into a 24-bit command
// and transmits 8-bit responses back to the host.
module cmd_uart_link
    import dso_uart_pkg::*;
#(
    parameter int BAUD_DIV    = DEF_BAUD_DIV,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frame_err
);

    localparam int            BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
    localparam int            IW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] TO_LAST   = IW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(CMD_BYTES - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic          rx_fall;
    rx_state_t     rx_state;
    logic [BW-1:0] rx_cnt;
    logic [2:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic          rx_done;
    logic [1:0]    byte_cnt;
    logic [IW-1:0] idle_cnt;
    logic          timed_out;

    assign rx_fall   = rx_prev & ~rx_sync;
    assign timed_out = (idle_cnt == TO_LAST);

    // Presetting to 1 keeps a reset from looking like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bits   <= '0;
            rx_shift  <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt   <= BAUD_HALF;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt   <= BAUD_LAST;
                        rx_bits  <= '0;
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_cnt   <= BAUD_LAST;
                        if (rx_bits == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            rx_bits <= rx_bits + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_state <= RX_IDLE;
                        if (rx_sync)
                            rx_done <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Bytes arriving while a command is still pending are silently discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
            byte_cnt <= '0;
        end else begin
            if (clr_cmd_rdy)
                cmd_rdy <= 1'b0;
            if (frame_err) begin
                byte_cnt <= '0;
            end else if (rx_done && !cmd_rdy) begin
                case (byte_cnt)
                    2'd0:    cmd[23:16] <= rx_shift;
                    2'd1:    cmd[15:8]  <= rx_shift;
                    default: cmd[7:0]   <= rx_shift;
                endcase
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt <= '0;
                    cmd_rdy  <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (timed_out) begin
                byte_cnt <= '0;
            end
        end
    end

    // Counts quiet line time only while a partial command is waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (rx_fall || byte_cnt == '0 || rx_state != RX_IDLE) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    uart_tx_core #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .trmt   (send_resp),
        .tx_data(resp_data),
        .TX     (TX),
        .tx_done(resp_sent),
        .tx_busy(tx_busy)
    );

endmodule

// File: tb/tb_cmd_uart_link.sv
// Self-checking bench for cmd_uart_link: table-driven commands, random traffic, corner sequences.
module tb_cmd_uart_link;

    localparam int BD = 16;
    localparam int TO = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int feCount = 0;
    int feRun = 0;
    int feMaxRun = 0;
    int rdyRiseCyc = -1000;
    logic rdyPrev = 1'b0;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [23:0] expCmd;
    } vec_t;

    vec_t vecs[8];

    cmd_uart_link #(
        .BAUD_DIV   (BD),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp_data  (resp_data),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent),
        .tx_busy    (tx_busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe pulse widths and the ready rising edge away from the active edge.
    always @(negedge clk) begin
        if (frame_err) begin
            feCount = feCount + 1;
            feRun = feRun + 1;
            if (feRun > feMaxRun) feMaxRun = feRun;
        end else begin
            feRun = 0;
        end
        if (cmd_rdy && !rdyPrev) rdyRiseCyc = cyc;
        rdyPrev = cmd_rdy;
    end

    // Reference: a command is simply the three bytes in arrival order.
    function automatic logic [23:0] modelCmd(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2);
        return {b0, b1, b2};
    endfunction

    // Reference: the serial frame is start 0, data LSB first, stop 1.
    function automatic logic modelTxBit(logic [7:0] d, int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return d[k-1];
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic sendByte(logic [7:0] d, logic stopBit);
        RX = 1'b0;
        tick(BD);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            tick(BD);
        end
        RX = stopBit;
        tick(BD);
        RX = 1'b1;
        tick(4);
    endtask

    task automatic waitRdy(string name);
        int n = 0;
        while (!cmd_rdy && n < 400) begin
            tick(1);
            n++;
        end
        checkOutput({name, "_rdy"}, {31'd0, cmd_rdy}, 32'd1);
    endtask

    task automatic clearRdy();
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic applyStimulus(vec_t v, string name);
        sendByte(v.b0, 1'b1);
        sendByte(v.b1, 1'b1);
        sendByte(v.b2, 1'b1);
        waitRdy(name);
        checkOutput({name, "_cmd"}, {8'd0, cmd}, {8'd0, v.expCmd});
        clearRdy();
        checkOutput({name, "_clr"}, {31'd0, cmd_rdy}, 32'd0);
        checkOutput({name, "_hold"}, {8'd0, cmd}, {8'd0, v.expCmd});
    endtask

    task automatic checkTx(logic [7:0] d, logic poke, string name);
        resp_data = d;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        checkOutput({name, "_busy0"}, {31'd0, tx_busy}, 32'd1);
        checkOutput({name, "_sent0"}, {31'd0, resp_sent}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick(8);
            checkOutput($sformatf("%s_bit%0d", name, k), {31'd0, TX}, {31'd0, modelTxBit(d, k)});
            if (poke && k == 4) begin
                resp_data = ~d;
                send_resp = 1'b1;
                tick(1);
                send_resp = 1'b0;
                tick(6);
            end else begin
                tick(7);
            end
            if (k == 9) checkOutput({name, "_busyEnd"}, {31'd0, tx_busy}, 32'd1);
            tick(1);
        end
        checkOutput({name, "_busyOff"}, {31'd0, tx_busy}, 32'd0);
        checkOutput({name, "_sent"}, {31'd0, resp_sent}, 32'd1);
        checkOutput({name, "_idleTx"}, {31'd0, TX}, 32'd1);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int lat;
        int feBase;
        logic [7:0] r0, r1, r2;

        vecs[0] = '{8'h06, 8'h2A, 8'h00, modelCmd(8'h06, 8'h2A, 8'h00)};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF, modelCmd(8'hFF, 8'h00, 8'hFF)};
        vecs[2] = '{8'hA5, 8'h5A, 8'h81, modelCmd(8'hA5, 8'h5A, 8'h81)};
        vecs[3] = '{8'h00, 8'h00, 8'h01, modelCmd(8'h00, 8'h00, 8'h01)};
        for (int i = 4; i < 8; i++) begin
            r0 = 8'($urandom_range(0, 255));
            r1 = 8'($urandom_range(0, 255));
            r2 = 8'($urandom_range(0, 255));
            vecs[i] = '{r0, r1, r2, modelCmd(r0, r1, r2)};
        end

        rst = 1'b1;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        resp_data = 8'h00;
        tick(3);
        checkOutput("rst_TX", {31'd0, TX}, 32'd1);
        checkOutput("rst_cmd", {8'd0, cmd}, 32'd0);
        checkOutput("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        checkOutput("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
        checkOutput("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        tick(5);

        // Basic command plus ready latency after the last stop bit.
        sendByte(8'h06, 1'b1);
        sendByte(8'h2A, 1'b1);
        t0 = cyc;
        sendByte(8'h00, 1'b1);
        lat = rdyRiseCyc - t0;
        checkOutput("t1_latency_window", {31'd0, (lat >= 150 && lat <= 160)}, 32'd1);
        checkOutput("t1_cmd", {8'd0, cmd}, 32'h062A00);
        clearRdy();
        checkOutput("t1_clr", {31'd0, cmd_rdy}, 32'd0);
        checkOutput("t1_hold", {8'd0, cmd}, 32'h062A00);

        // Byte arriving while a command is pending must be dropped.
        sendByte(8'h33, 1'b1);
        sendByte(8'h44, 1'b1);
        sendByte(8'h55, 1'b1);
        waitRdy("t2a");
        sendByte(8'h09, 1'b1);
        checkOutput("t2_pending_cmd", {8'd0, cmd}, 32'h334455);
        checkOutput("t2_pending_rdy", {31'd0, cmd_rdy}, 32'd1);
        clearRdy();
        applyStimulus('{8'h02, 8'h11, 8'h00, modelCmd(8'h02, 8'h11, 8'h00)}, "t2");

        // Partial command discarded after the idle timeout.
        sendByte(8'h03, 1'b1);
        sendByte(8'h80, 1'b1);
        tick(TO + 100);
        applyStimulus('{8'h04, 8'h01, 8'hFF, modelCmd(8'h04, 8'h01, 8'hFF)}, "t3");

        // Bad stop bit: single pulse and the partial command restarts.
        sendByte(8'h77, 1'b1);
        feBase = feCount;
        sendByte(8'h55, 1'b0);
        tick(8);
        checkOutput("t4_fe_count", feCount - feBase, 32'd1);
        checkOutput("t4_fe_width", feMaxRun, 32'd1);
        applyStimulus('{8'h01, 8'h02, 8'h00, modelCmd(8'h01, 8'h02, 8'h00)}, "t4");

        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Transmit path, including an ignored request mid-frame.
        checkTx(8'hA5, 1'b1, "t5");
        for (int i = 0; i < 3; i++)
            checkTx(8'($urandom_range(0, 255)), 1'b0, $sformatf("txr%0d", i));

        // Reset in the middle of RX byte 2 and an active transmission.
        sendByte(8'hAA, 1'b1);
        resp_data = 8'h5A;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        RX = 1'b0;
        tick(40);
        checkOutput("t6_busy_before", {31'd0, tx_busy}, 32'd1);
        rst = 1'b1;
        RX = 1'b1;
        tick(1);
        checkOutput("t6_TX", {31'd0, TX}, 32'd1);
        checkOutput("t6_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("t6_sent", {31'd0, resp_sent}, 32'd0);
        checkOutput("t6_cmd", {8'd0, cmd}, 32'd0);
        checkOutput("t6_rdy", {31'd0, cmd_rdy}, 32'd0);
        rst = 1'b0;
        tick(BD * 12);
        applyStimulus('{8'h7E, 8'h00, 8'hC3, modelCmd(8'h7E, 8'h00, 8'hC3)}, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_uart_link.md
Name: cmd_uart_link

Overview:
- Host-side serial link for the scope's command processor.
- Deserializes UART bytes from the host and assembles each group of three into a 24-bit command, presented on the cmd/cmd_rdy/clr_cmd_rdy handshake.
- Serializes 8-bit responses presented on the resp_data/send_resp/resp_sent handshake back to the host.
- Sits between the board RX/TX pins and the command decoder.

Parameters:
- BAUD_DIV, 2604: clk cycles per bit (50 MHz / 19200). Must be at least 8.
- TIMEOUT_CYC, 1000000: idle clk cycles after which a partial command is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- RX  in  1  async serial input, idle high
- TX  out  1  serial output, idle high
- cmd  out  24  assembled command; byte0 in [23:16], byte1 in [15:8], byte2 in [7:0]
- cmd_rdy  out  1  level; a complete command is valid on cmd
- clr_cmd_rdy  in  1  pulse; consumer releases cmd
- resp_data  in  8  response byte
- send_resp  in  1  pulse; start transmitting resp_data
- resp_sent  out  1  level; last response fully shifted out
- tx_busy  out  1  transmitter active
- frame_err  out  1  one-cycle pulse on a bad stop bit

Behaviour:
- Reset values (sync, active-high), all applied on the clock edge where rst=1:
  - TX=1, cmd=0, cmd_rdy=0, resp_sent=0, tx_busy=0, frame_err=0.
  - RX synchronizer flops preset to 1; both FSMs return to IDLE; byte counter = 0.
- Reset mid-frame aborts both directions immediately. TX returns high on the next cycle.
- RX input: 2-flop synchronizer, followed by a falling-edge detect on the synchronized value.
- RX FSM states IDLE, START, DATA, STOP:
  - IDLE: on a falling edge, go to START and load the baud counter with BAUD_DIV/2.
  - START: at count expiry, sample the line. If it reads 1 (glitch), return to IDLE. Otherwise go to DATA with the counter loaded to BAUD_DIV.
  - DATA: sample 8 bits LSB-first, one every BAUD_DIV cycles (mid-bit).
  - STOP: sample one stop bit.
    - Stop = 1: byte accepted.
    - Stop = 0: frame_err pulses, the byte is dropped and the byte counter resets to 0.
  - Return to IDLE after STOP in either case.
- Assembler, byte counter 0..2:
  - An accepted byte is stored only if the registered cmd_rdy is 0 in the acceptance cycle. Otherwise it is discarded and the counter is unchanged.
  - Counter 0 writes cmd[23:16], 1 writes [15:8], 2 writes [7:0].
  - On the counter-2 write, the counter wraps to 0 and cmd_rdy=1 on the next edge. Latency is one cycle after the stop-bit sample.
  - cmd is held stable while cmd_rdy=1.
  - clr_cmd_rdy forces cmd_rdy to 0 on the next edge; cmd retains its value.
  - A byte accepted in the same cycle as clr_cmd_rdy is dropped, because the registered cmd_rdy is still 1.
- Timeout: an idle counter runs while the byte counter is non-zero and the RX FSM is in IDLE. It resets on every falling edge. Reaching TIMEOUT_CYC clears the byte counter; the partial command is lost and cmd_rdy is unaffected.
- TX FSM states IDLE, XMIT:
  - send_resp in IDLE: latch resp_data into a 10-bit shift register {1, data, 0}. tx_busy=1 and resp_sent=0 on the next edge; TX drives the start bit from the next cycle.
  - Each bit is held for BAUD_DIV cycles, LSB first, then the stop bit.
  - After 10 bit-times, return to IDLE: tx_busy=0, resp_sent=1. resp_sent holds until the next accepted send_resp or reset.
  - send_resp while tx_busy=1 is ignored, with no queueing.
- RX and TX are fully independent; full-duplex operation is legal.

Decomposition:
- Package dso_uart_pkg:
  - typedefs rx_state_t {IDLE, START, DATA, STOP} and tx_state_t {IDLE, XMIT};
  - localparams CMD_BYTES=3 and DEF_BAUD_DIV=2604.
- One sub-module, uart_tx_core: the baud counter, bit counter, shift register and TX FSM, with ports clk, rst, trmt, tx_data, TX, tx_done, tx_busy.
- The RX path and assembler stay in the top module.

Test Plan (BAUD_DIV=16, TIMEOUT_CYC=2000):
1. Host sends 0x06, 0x2A, 0x00 -> cmd=24'h062A00 and cmd_rdy=1 exactly one cycle after the third stop sample. Then clr_cmd_rdy pulse -> cmd_rdy=0 next cycle, cmd still 24'h062A00.
2. While cmd_rdy=1, host sends 0x09 -> byte dropped. After clr, send 0x02, 0x11, 0x00 -> cmd=24'h021100.
3. Host sends 0x03, 0x80, then idles 2000 cycles; then sends 0x04, 0x01, 0xFF -> cmd=24'h0401FF, with no stale 0x03 in any byte.
4. Byte 0x55 with stop bit forced 0 -> frame_err single-cycle pulse and counter reset. Then 0x01, 0x02, 0x00 -> cmd=24'h010200.
5. send_resp with resp_data=0xA5 -> TX shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 16 cycles. tx_busy high for 160 cycles, then resp_sent=1. A second send_resp mid-frame produces no change.
6. Assert rst during RX byte 2 and during TX -> all outputs at reset values next edge, TX=1. A fresh 3-byte command afterwards assembles correctly.
